// File: rtl/npu_pkg.sv
// npu_pkg: shared state type and arithmetic helpers for the NPU conv datapath.
// Lane ReLU is compiled in only when CONV_RELU_EN is defined.
package npu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        OUTPUT,
        DONE
    } conv_state_t;

    // Widest accumulator the saturation helper can take
    localparam int SAT_WIDTH = 64;

    function automatic int min_acc_width(input int k, input int dw);
        return 2 * dw + $clog2(k * k);
    endfunction

    // Clamped to the signed dw-bit range; caller keeps the low dw bits
    function automatic logic signed [SAT_WIDTH-1:0] sat_signed(
        input logic signed [SAT_WIDTH-1:0] acc,
        input int                          shift,
        input int                          dw
    );
        logic signed [SAT_WIDTH-1:0] one;
        logic signed [SAT_WIDTH-1:0] s;
        logic signed [SAT_WIDTH-1:0] hi;
        logic signed [SAT_WIDTH-1:0] lo;
        one = 1;
        s   = acc >>> shift;
        hi  = (one <<< (dw - 1)) - one;
        lo  = -hi - one;
        if (s > hi)
            return hi;
        if (s < lo)
            return lo;
        return s;
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// conv_mac_lane: one window's MAC, shift and saturate stage.
// CONV_RELU_EN forces negative saturated results to zero.
module conv_mac_lane
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         clear,
    input  logic                         acc_en,
    input  logic                         load,
    input  logic signed [DATA_WIDTH-1:0] pixel,
    input  logic signed [DATA_WIDTH-1:0] weight,
    output logic signed [DATA_WIDTH-1:0] result
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  prod_x;
    logic signed [SAT_WIDTH-1:0]  acc_x;
    logic signed [SAT_WIDTH-1:0]  sat_x;
    logic signed [DATA_WIDTH-1:0] sat_res;
    logic                         unused_sat_hi;

    assign prod   = pixel * weight;
    assign prod_x = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
    assign acc_x  = {{(SAT_WIDTH - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    assign sat_x  = sat_signed(acc_x, OUT_SHIFT, DATA_WIDTH);
    assign unused_sat_hi = ^sat_x[SAT_WIDTH-1:DATA_WIDTH];

    always_comb begin
        sat_res = sat_x[DATA_WIDTH-1:0];
`ifdef CONV_RELU_EN
        if (sat_res[DATA_WIDTH-1])
            sat_res = '0;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (clear)
                acc <= '0;
            else if (acc_en)
                acc <= acc + prod_x;
            if (load)
                result <= sat_res;
        end
    end

endmodule

// File: rtl/conv_window_engine.sv
// conv_window_engine: K x K signed convolution over NUM_WINDOWS parallel windows.
// Define CONV_RELU_EN to clamp negative lane results to zero.
module conv_window_engine
    import npu_pkg::*;
#(
    parameter int KERNEL_SIZE       = 3,
    parameter int DATA_WIDTH        = 8,
    parameter int ACC_WIDTH         = 20,
    parameter int NUM_WINDOWS       = 2,
    parameter int SRAM_ADDR_WIDTH   = 4,
    parameter int KERNEL_ADDR_WIDTH = 6,
    parameter int OUT_SHIFT         = 0
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    input  logic [KERNEL_ADDR_WIDTH-1:0]        i_kernel_base,
    output logic [KERNEL_ADDR_WIDTH-1:0]        o_kernel_addr,
    input  logic [DATA_WIDTH-1:0]               i_kernel_data,
    output logic [SRAM_ADDR_WIDTH-1:0]          o_win_addr,
    input  logic [NUM_WINDOWS*DATA_WIDTH-1:0]   i_win_data,
    output logic [NUM_WINDOWS*DATA_WIDTH-1:0]   o_result,
    output logic                                o_valid,
    output logic                                o_busy,
    output logic                                o_done
);

    localparam int TAPS = KERNEL_SIZE * KERNEL_SIZE;
    localparam int TW   = SRAM_ADDR_WIDTH + 1;
    localparam logic [TW-1:0] TAPS_T = TW'(TAPS);
    localparam logic [TW-1:0] TAP_ONE = TW'(1);
    localparam logic [TW-1:0] TAP_TWO = TW'(2);

    if (ACC_WIDTH < min_acc_width(KERNEL_SIZE, DATA_WIDTH)) begin : g_bad_acc
        $error("ACC_WIDTH too small for KERNEL_SIZE/DATA_WIDTH");
    end
    if (ACC_WIDTH > SAT_WIDTH) begin : g_wide_acc
        $error("ACC_WIDTH exceeds saturation helper width");
    end
    if ((1 << SRAM_ADDR_WIDTH) < TAPS) begin : g_bad_sram
        $error("SRAM_ADDR_WIDTH cannot address all taps");
    end
    if (KERNEL_SIZE < 2) begin : g_bad_k
        $error("KERNEL_SIZE must be at least 2");
    end

    conv_state_t                  state;
    logic [TW-1:0]                tap;
    logic [KERNEL_ADDR_WIDTH-1:0] base_q;
    logic                         go;
    logic                         acc_en;
    logic                         load;

    assign go = i_start && (state == IDLE || state == DONE);
    // Read data lags the issued address by two edges
    assign acc_en = (state == FETCH && tap >= TAP_TWO)
                 || (state == DRAIN);
    assign load = (state == OUTPUT);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state         <= IDLE;
            tap           <= '0;
            base_q        <= '0;
            o_win_addr    <= '0;
            o_kernel_addr <= '0;
            o_valid       <= 1'b0;
            o_done        <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        state         <= FETCH;
                        base_q        <= i_kernel_base;
                        tap           <= TAP_ONE;
                        o_win_addr    <= '0;
                        o_kernel_addr <= i_kernel_base;
                        o_busy        <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                FETCH: begin
                    if (tap == TAPS_T) begin
                        state <= DRAIN;
                    end else begin
                        o_win_addr    <= tap[SRAM_ADDR_WIDTH-1:0];
                        o_kernel_addr <= base_q + KERNEL_ADDR_WIDTH'(tap);
                        tap           <= tap + TAP_ONE;
                    end
                end
                DRAIN: begin
                    state <= OUTPUT;
                end
                OUTPUT: begin
                    state   <= DONE;
                    o_valid <= 1'b1;
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    for (genvar n = 0; n < NUM_WINDOWS; n++) begin : g_lane
        conv_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .OUT_SHIFT  (OUT_SHIFT)
        ) u_lane (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .clear  (go),
            .acc_en (acc_en),
            .load   (load),
            .pixel  (i_win_data[n*DATA_WIDTH +: DATA_WIDTH]),
            .weight (i_kernel_data),
            .result (o_result[n*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_conv_window_engine.sv
// tb_conv_window_engine: randomized jobs against a sum-of-products reference.
// Two engines share stimulus: OUT_SHIFT=0 and OUT_SHIFT=2.
module tb_conv_window_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  kbase;
    logic [7:0]  kdata;
    logic [15:0] wdata;

    logic [5:0]  kaddr0, kaddr1;
    logic [3:0]  waddr0, waddr1;
    logic [15:0] res0, res1;
    logic        valid0, busy0, done0;
    logic        valid1, busy1, done1;

    logic signed [7:0] kmem [64];
    logic signed [7:0] wmem [2][16];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_window_engine u_dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_start       (start),
        .i_kernel_base (kbase),
        .o_kernel_addr (kaddr0),
        .i_kernel_data (kdata),
        .o_win_addr    (waddr0),
        .i_win_data    (wdata),
        .o_result      (res0),
        .o_valid       (valid0),
        .o_busy        (busy0),
        .o_done        (done0)
    );

    conv_window_engine #(.OUT_SHIFT(2)) u_dut_sh (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_start       (start),
        .i_kernel_base (kbase),
        .o_kernel_addr (kaddr1),
        .i_kernel_data (kdata),
        .o_win_addr    (waddr1),
        .i_win_data    (wdata),
        .o_result      (res1),
        .o_valid       (valid1),
        .o_busy        (busy1),
        .o_done        (done1)
    );

    // Synchronous-read kernel RF and window SRAMs
    always @(posedge clk) begin
        kdata <= kmem[kaddr0];
        wdata <= {wmem[1][waddr0], wmem[0][waddr0]};
    end

    task automatic check(input string tag,
                         input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint model(int lane, int base, int sh);
        longint acc = 0;
        for (int t = 0; t < 9; t++)
            acc += longint'(kmem[(base + t) % 64]) * longint'(wmem[lane][t]);
        acc = acc >>> sh;
        if (acc > 127)
            acc = 127;
        if (acc < -128)
            acc = -128;
`ifdef CONV_RELU_EN
        if (acc < 0)
            acc = 0;
`endif
        return acc;
    endfunction

    task automatic fill_const(input int kv, input int w0, input int w1);
        for (int i = 0; i < 64; i++)
            kmem[i] = 8'(kv);
        for (int i = 0; i < 16; i++) begin
            wmem[0][i] = 8'(w0);
            wmem[1][i] = 8'(w1);
        end
    endtask

    function automatic logic [7:0] rnd8();
        int r = $urandom_range(0, 9);
        if (r == 0)
            return 8'h7f;
        if (r == 1)
            return 8'h80;
        return 8'($urandom);
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < 64; i++)
            kmem[i] = rnd8();
        for (int i = 0; i < 16; i++) begin
            wmem[0][i] = rnd8();
            wmem[1][i] = rnd8();
        end
    endtask

    task automatic begin_job(input int base);
        @(negedge clk);
        kbase = 6'(base);
        start = 1'b1;
    endtask

    // Cycle c is the half-period after edge c; edge 0 samples start
    task automatic watch_job(input int base, input int mid_start,
                             input bit chain, input int next_base);
        longint e0, e1, s0, s1;
        int done_at = -1;
        e0 = model(0, base, 0);
        e1 = model(1, base, 0);
        s0 = model(0, base, 2);
        s1 = model(1, base, 2);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            start = (c == mid_start);
            if (c <= 8) begin
                check("win_addr", waddr0, c);
                check("kern_addr", kaddr0, (base + c) % 64);
                check("kern_addr_sh", kaddr1, (base + c) % 64);
            end
            if (c == 5)
                check("busy_mid", busy0, 1);
            if (done0) begin
                done_at = c;
                check("valid", valid0, 1);
                check("busy_done", busy0, 0);
                check("lane0", $signed(res0[7:0]), e0);
                check("lane1", $signed(res0[15:8]), e1);
                check("done_sh", done1, 1);
                check("valid_sh", valid1, 1);
                check("busy_sh", busy1, 0);
                check("lane0_sh", $signed(res1[7:0]), s0);
                check("lane1_sh", $signed(res1[15:8]), s1);
                check("win_addr_sh", waddr1, 8);
                if (chain) begin
                    start = 1'b1;
                    kbase = 6'(next_base);
                end
                break;
            end
        end
        check("done_cycle", done_at, 11);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done0)
                n++;
        end
    endtask

    initial begin
        int n;
        logic [15:0] held;
        rst_n = 1'b0;
        start = 1'b0;
        kbase = '0;
        fill_const(1, 2, 3);
        repeat (3) @(negedge clk);
        check("rst_result", res0, 0);
        check("rst_valid", valid0, 0);
        check("rst_done", done0, 0);
        check("rst_busy", busy0, 0);
        check("rst_waddr", waddr0, 0);
        check("rst_kaddr", kaddr0, 0);
        rst_n = 1'b1;

        // Uniform data, expected lanes {27,18}
        begin_job(0);
        watch_job(0, -1, 0, 0);
        check("t1_lane0", $signed(res0[7:0]), 18);
        check("t1_lane1", $signed(res0[15:8]), 27);

        // Positive and negative saturation
        fill_const(127, 127, 127);
        begin_job(0);
        watch_job(0, -1, 0, 0);
        fill_const(127, -128, -128);
        begin_job(0);
        watch_job(0, -1, 0, 0);

        fill_const(1, -5, -5);
        begin_job(3);
        watch_job(3, -1, 0, 0);

        // Kernel address wrap
        fill_rand();
        begin_job(60);
        watch_job(60, -1, 0, 0);

        // Start while busy is ignored; result then holds
        fill_rand();
        begin_job(17);
        watch_job(17, 5, 0, 0);
        held = res0;
        count_dones(15, n);
        check("extra_done", n, 0);
        check("hold", res0, held);

        // Back-to-back jobs from DONE
        fill_rand();
        begin_job(5);
        watch_job(5, -1, 1, 40);
        watch_job(40, -1, 0, 0);

        // Abort by reset in cycle 4
        fill_const(3, 4, 5);
        begin_job(9);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy0, 0);
        check("abort_result", res0, 0);
        check("abort_waddr", waddr0, 0);
        check("abort_kaddr", kaddr0, 0);
        check("abort_done", done0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_dones(15, n);
        check("abort_no_done", n, 0);
        begin_job(9);
        watch_job(9, -1, 0, 0);

        for (int j = 0; j < 12; j++) begin
            int b;
            b = $urandom_range(0, 63);
            fill_rand();
            begin_job(b);
            watch_job(b, -1, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
